microcode_stack_sequencer: RTL and testbench
============================================

// Module: microcode_stack_sequencer
// PURPOSE
//  Parametrised next-generation microcode address sequencer for the SOL-1 control unit.
//  Generates the next u_address each clock from the control-word branch type:
//   - relative and conditional jumps
//   - fetch/trap dispatch
//   - IR dispatch
//  Adds three things the first generation lacks: a micro-subroutine call/return stack,
//  a hardware loop counter, and a stall input. Drives the control ROM address.
// PARAMETERS
//  UADDR_W     14  micro-address width
//  IR_W         8  opcode width, zero-extended for IR dispatch
//  OFFSET_W     7  unsigned jump offset width
//  STACK_DEPTH  4  return-stack entries (>=1)
//  LOOP_W       8  loop counter width
//  NUM_COND    16  condition inputs selectable by cond_sel
// PORTS
//  clk                  in   1                      system clock, rising edge
//  arst_n               in   1                      reset; one clock; asynchronous, active-low
//  stall                in   1                      1 = hold all state (memory wait)
//  ctrl_typ             in   3                      branch type, see BEHAVIOUR
//  ctrl_offset          in   OFFSET_W               jump offset
//  ctrl_cond_sel        in   $clog2(NUM_COND)       condition select
//  ctrl_cond_invert     in   1                      invert selected condition
//  ctrl_immy            in   LOOP_W                 loop count immediate
//  cond_vec             in   NUM_COND               flag/status conditions, pre-muxed by caller
//  ir                   in   IR_W                   instruction register
//  any_interruption     in   1                      dma_req | int_pending
//  fetch_u_address      in   UADDR_W                fetch routine entry
//  trap_u_address       in   UADDR_W                trap routine entry
//  err_clr              in   1                      clear sticky errors
//  u_address            out  UADDR_W                current micro-address (registered)
//  stack_level          out  $clog2(STACK_DEPTH+1)  entries in use
//  loop_count           out  LOOP_W                 loop counter
//  err_overflow         out  1                      sticky: call with stack full
//  err_underflow        out  1                      sticky: return with stack empty
// BEHAVIOUR
//  Reset (arst_n low, async): u_address=0, stack_level=0, loop_count=0, both errors=0.
//   Stack contents are don't-care.
//  Notation: A=u_address, off=zero-ext ctrl_offset, all sums modulo 2**UADDR_W (wrap).
//   c = cond_vec[ctrl_cond_sel] ^ ctrl_cond_invert.
//  One decision per clock, 1-cycle latency: ctrl_* of the current word selects next A.
//  stall=1: A, stack, loop_count, errors all hold; err_clr is also ignored.
//  ctrl_typ:
//   000 JMP   A <= A+off
//   001 CJMP  A <= c ? A+off : A+1
//   010 DISP  A <= any_interruption ? trap_u_address : fetch_u_address
//   011 IRDSP A <= zero-ext ir
//   100 CALL  push A+1; A <= A+off; stack_level++
//   101 RET   A <= top; pop; stack_level--
//   110 LOOP  if loop_count!=0: loop_count--, A <= A+off
//             else A <= A+1 (count stays 0)
//   111 LDLP  loop_count <= ctrl_immy; A <= A+1
//  Boundaries:
//   - CALL at stack_level==STACK_DEPTH: no push, level unchanged, err_overflow<=1,
//     A <= A+off anyway.
//   - RET at stack_level==0: A <= fetch_u_address, err_underflow<=1, level stays 0.
//   - LOOP with loop_count==1: decrements to 0 and branches; the next LOOP falls through.
//     LDLP 0 therefore gives zero branches.
//   - Stack is LIFO, top = most recent push; nested calls to full depth return in
//     reverse order.
//   - err_clr clears both errors next clock. An error set in the same cycle wins
//     over err_clr.
//   - Reset asserted mid-operation clears everything immediately.
//   - On reset release, the first clock evaluates ctrl_* with A=0.
// TESTING
//  1 Reset: hold arst_n=0, toggle clk -> u_address=0, stack_level=0, loop_count=0,
//    errors=0; release, JMP off=5 -> u_address=5.
//  2 Cond/wrap: A=0x3FFE, JMP off=3 -> 0x0001; CJMP with cond_vec[4]=1, sel=4,
//    invert=1, off=9 -> A+1.
//  3 Call/return: CALL at A=0x100 off=0x20, CALL at 0x120 off=0x10, RET, RET
//    -> A = 0x120, 0x130, 0x121, 0x101; level 1,2,1,0.
//  4 Overflow/underflow: 5 CALLs with STACK_DEPTH=4 -> err_overflow=1, level=4;
//    5 RETs -> 4 pops, then A=fetch_u_address, err_underflow=1;
//    err_clr -> both 0.
//  5 Loop: LDLP 3, then LOOP off=0 repeatedly -> A held 3 more cycles (count 2,1,0),
//    then A+1.
//  6 Dispatch/stall: DISP with any_interruption=1 -> trap_u_address; stall=1 during
//    CALL -> no state change until stall drops.

Source files
------------

// File: rtl/microcode_stack_sequencer.sv
// microcode_stack_sequencer
//   Next-address generator for the SOL-1 control unit. Each clock it picks the next
//   micro-address from the control-word branch type. Beyond plain jumps and dispatch,
//   it provides a micro-subroutine return stack, a hardware loop counter and a stall
//   hold.
// Ports
//   clk, arst_n              clock (rising edge), asynchronous active-low reset
//   stall                    holds every piece of state, including errors
//   ctrl_typ/offset/cond_sel/cond_invert/immy
//                            fields of the current control word
//   cond_vec                 condition flags selected by ctrl_cond_sel
//   ir                       opcode used for IR dispatch
//   any_interruption         selects the trap entry on DISP
//   fetch_u_address          fetch entry; also the landing point of an underflowing RET
//   trap_u_address           trap entry
//   err_clr                  clears the sticky error flags
//   u_address                registered micro-address driving the control ROM
//   stack_level              number of return-stack entries in use
//   loop_count               hardware loop counter
//   err_overflow             sticky flag: CALL issued with the stack full
//   err_underflow            sticky flag: RET issued with the stack empty
module microcode_stack_sequencer #(
    parameter int UADDR_W     = 14,
    parameter int IR_W        = 8,
    parameter int OFFSET_W    = 7,
    parameter int STACK_DEPTH = 4,
    parameter int LOOP_W      = 8,
    parameter int NUM_COND    = 16,
    localparam int SEL_W      = (NUM_COND > 1) ? $clog2(NUM_COND) : 1,
    localparam int LVL_W      = $clog2(STACK_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                stall,
    input  logic [2:0]          ctrl_typ,
    input  logic [OFFSET_W-1:0] ctrl_offset,
    input  logic [SEL_W-1:0]    ctrl_cond_sel,
    input  logic                ctrl_cond_invert,
    input  logic [LOOP_W-1:0]   ctrl_immy,
    input  logic [NUM_COND-1:0] cond_vec,
    input  logic [IR_W-1:0]     ir,
    input  logic                any_interruption,
    input  logic [UADDR_W-1:0]  fetch_u_address,
    input  logic [UADDR_W-1:0]  trap_u_address,
    input  logic                err_clr,
    output logic [UADDR_W-1:0]  u_address,
    output logic [LVL_W-1:0]    stack_level,
    output logic [LOOP_W-1:0]   loop_count,
    output logic                err_overflow,
    output logic                err_underflow
);

    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] TYP_JMP   = 3'b000;
    localparam logic [2:0] TYP_CJMP  = 3'b001;
    localparam logic [2:0] TYP_DISP  = 3'b010;
    localparam logic [2:0] TYP_IRDSP = 3'b011;
    localparam logic [2:0] TYP_CALL  = 3'b100;
    localparam logic [2:0] TYP_RET   = 3'b101;
    localparam logic [2:0] TYP_LOOP  = 3'b110;
    localparam logic [2:0] TYP_LDLP  = 3'b111;

    logic [UADDR_W-1:0] stack_mem [STACK_DEPTH];

    logic [UADDR_W-1:0] addr_inc;
    logic [UADDR_W-1:0] addr_off;
    logic [UADDR_W-1:0] stack_top;
    logic [PTR_W-1:0]   push_idx;
    logic [PTR_W-1:0]   top_idx;
    logic               cond;
    logic               stack_full;
    logic               stack_empty;

    logic [UADDR_W-1:0] addr_nxt;
    logic [LVL_W-1:0]   level_nxt;
    logic [LOOP_W-1:0]  loop_nxt;
    logic               push_en;
    logic               set_ovf;
    logic               set_unf;

    // Sums wrap naturally at UADDR_W bits.
    assign addr_inc    = u_address + UADDR_W'(1);
    assign addr_off    = u_address + UADDR_W'(ctrl_offset);
    assign cond        = cond_vec[ctrl_cond_sel] ^ ctrl_cond_invert;
    assign stack_full  = (stack_level == LVL_W'(STACK_DEPTH));
    assign stack_empty = (stack_level == '0);
    // The level counts entries, so it doubles as the push slot; the top is one below.
    // When empty the top index wraps, but it is never used then.
    assign push_idx    = PTR_W'(stack_level);
    assign top_idx     = PTR_W'(stack_level - LVL_W'(1));
    assign stack_top   = stack_mem[top_idx];

    always_comb begin
        addr_nxt  = addr_inc;
        level_nxt = stack_level;
        loop_nxt  = loop_count;
        push_en   = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        case (ctrl_typ)
            TYP_JMP:   addr_nxt = addr_off;
            TYP_CJMP:  addr_nxt = cond ? addr_off : addr_inc;
            TYP_DISP:  addr_nxt = any_interruption ? trap_u_address : fetch_u_address;
            TYP_IRDSP: addr_nxt = UADDR_W'(ir);
            TYP_CALL: begin
                // The jump happens even when the push is dropped on overflow.
                addr_nxt = addr_off;
                if (stack_full) begin
                    set_ovf = 1'b1;
                end else begin
                    push_en   = 1'b1;
                    level_nxt = stack_level + LVL_W'(1);
                end
            end
            TYP_RET: begin
                if (stack_empty) begin
                    addr_nxt = fetch_u_address;
                    set_unf  = 1'b1;
                end else begin
                    addr_nxt  = stack_top;
                    level_nxt = stack_level - LVL_W'(1);
                end
            end
            TYP_LOOP: begin
                if (loop_count != '0) begin
                    loop_nxt = loop_count - LOOP_W'(1);
                    addr_nxt = addr_off;
                end
            end
            TYP_LDLP:  loop_nxt = ctrl_immy;
            default:   addr_nxt = addr_inc;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            u_address     <= '0;
            stack_level   <= '0;
            loop_count    <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else if (!stall) begin
            u_address   <= addr_nxt;
            stack_level <= level_nxt;
            loop_count  <= loop_nxt;
            // A newly detected error takes priority over a clear in the same cycle.
            if (set_ovf)      err_overflow <= 1'b1;
            else if (err_clr) err_overflow <= 1'b0;
            if (set_unf)       err_underflow <= 1'b1;
            else if (err_clr)  err_underflow <= 1'b0;
        end
    end

    // Stack contents need no reset; only the level decides what is valid.
    always_ff @(posedge clk) begin
        if (!stall && push_en) begin
            stack_mem[push_idx] <= addr_inc;
        end
    end

endmodule

// File: tb/tb_microcode_stack_sequencer.sv
module tb_microcode_stack_sequencer;

    localparam int UADDR_W = 14;

    localparam logic [2:0] JMP   = 3'b000;
    localparam logic [2:0] CJMP  = 3'b001;
    localparam logic [2:0] DISP  = 3'b010;
    localparam logic [2:0] IRDSP = 3'b011;
    localparam logic [2:0] CALL  = 3'b100;
    localparam logic [2:0] RET   = 3'b101;
    localparam logic [2:0] LOOP  = 3'b110;
    localparam logic [2:0] LDLP  = 3'b111;

    logic               clk = 1'b0;
    logic               arst_n;
    logic               stall;
    logic [2:0]         ctrl_typ;
    logic [6:0]         ctrl_offset;
    logic [3:0]         ctrl_cond_sel;
    logic               ctrl_cond_invert;
    logic [7:0]         ctrl_immy;
    logic [15:0]        cond_vec;
    logic [7:0]         ir;
    logic               any_interruption;
    logic [UADDR_W-1:0] fetch_u_address;
    logic [UADDR_W-1:0] trap_u_address;
    logic               err_clr;
    logic [UADDR_W-1:0] u_address;
    logic [2:0]         stack_level;
    logic [7:0]         loop_count;
    logic               err_overflow;
    logic               err_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    microcode_stack_sequencer dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .stall            (stall),
        .ctrl_typ         (ctrl_typ),
        .ctrl_offset      (ctrl_offset),
        .ctrl_cond_sel    (ctrl_cond_sel),
        .ctrl_cond_invert (ctrl_cond_invert),
        .ctrl_immy        (ctrl_immy),
        .cond_vec         (cond_vec),
        .ir               (ir),
        .any_interruption (any_interruption),
        .fetch_u_address  (fetch_u_address),
        .trap_u_address   (trap_u_address),
        .err_clr          (err_clr),
        .u_address        (u_address),
        .stack_level      (stack_level),
        .loop_count       (loop_count),
        .err_overflow     (err_overflow),
        .err_underflow    (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one control word, let it be clocked in, then sample 1 ns after the edge.
    task automatic op(input logic [2:0] typ, input logic [6:0] off);
        ctrl_typ    = typ;
        ctrl_offset = off;
        @(posedge clk);
        #1;
    endtask

    task automatic check_al(input string tag, input logic [31:0] a, input logic [31:0] lvl);
        check({tag, "_addr"}, 32'(u_address), a);
        check({tag, "_lvl"}, 32'(stack_level), lvl);
    endtask

    initial begin
        arst_n           = 1'b0;
        stall            = 1'b0;
        ctrl_typ         = JMP;
        ctrl_offset      = '0;
        ctrl_cond_sel    = '0;
        ctrl_cond_invert = 1'b0;
        ctrl_immy        = '0;
        cond_vec         = '0;
        ir               = '0;
        any_interruption = 1'b0;
        fetch_u_address  = '0;
        trap_u_address   = '0;
        err_clr          = 1'b0;

        // Reset
        ctrl_offset = 7'd9;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", 32'(u_address), 32'h0);
        check("rst_lvl", 32'(stack_level), 32'h0);
        check("rst_loop", 32'(loop_count), 32'h0);
        check("rst_ovf", 32'(err_overflow), 32'h0);
        check("rst_unf", 32'(err_underflow), 32'h0);
        arst_n = 1'b1;
        op(JMP, 7'd5);
        check("jmp5", 32'(u_address), 32'h5);

        // Dispatch, wrap, conditional jump, IR dispatch
        fetch_u_address = 14'h3FFE;
        op(DISP, 7'd0);
        check("disp_fetch", 32'(u_address), 32'h3FFE);
        op(JMP, 7'd3);
        check("jmp_wrap", 32'(u_address), 32'h0001);
        cond_vec         = 16'h0010;
        ctrl_cond_sel    = 4'd4;
        ctrl_cond_invert = 1'b1;
        op(CJMP, 7'd9);
        check("cjmp_not_taken", 32'(u_address), 32'h0002);
        ctrl_cond_invert = 1'b0;
        op(CJMP, 7'd9);
        check("cjmp_taken", 32'(u_address), 32'h000B);
        ir = 8'hA5;
        op(IRDSP, 7'd0);
        check("irdsp", 32'(u_address), 32'h00A5);

        // Call / return
        fetch_u_address = 14'h0100;
        op(DISP, 7'd0);
        check("disp_100", 32'(u_address), 32'h0100);
        op(CALL, 7'h20);
        check_al("call1", 32'h120, 1);
        op(CALL, 7'h10);
        check_al("call2", 32'h130, 2);
        op(RET, 7'd0);
        check_al("ret1", 32'h121, 1);
        op(RET, 7'd0);
        check_al("ret2", 32'h101, 0);

        // Overflow: pushes 0x102..0x105, fifth call jumps without pushing
        for (int i = 1; i <= 5; i++) begin
            op(CALL, 7'd1);
            check_al($sformatf("ovf_call%0d", i), 32'h101 + 32'(i), (i > 4) ? 4 : i);
        end
        check("ovf_flag", 32'(err_overflow), 32'h1);
        check("ovf_unf_clear", 32'(err_underflow), 32'h0);

        // Underflow: LIFO pops, then fetch entry on the empty RET
        fetch_u_address = 14'h0200;
        for (int i = 0; i < 4; i++) begin
            op(RET, 7'd0);
            check_al($sformatf("unf_ret%0d", i), 32'h105 - 32'(i), 3 - i);
        end
        op(RET, 7'd0);
        check_al("unf_ret_empty", 32'h200, 0);
        check("unf_flag", 32'(err_underflow), 32'h1);
        check("unf_ovf_sticky", 32'(err_overflow), 32'h1);

        // Error set in the same cycle as err_clr wins; overflow is cleared
        err_clr = 1'b1;
        op(RET, 7'd0);
        check("clr_unf_wins", 32'(err_underflow), 32'h1);
        check("clr_ovf", 32'(err_overflow), 32'h0);
        op(JMP, 7'd0);
        check("clr_unf", 32'(err_underflow), 32'h0);
        check("clr_addr", 32'(u_address), 32'h200);
        err_clr = 1'b0;

        // Hardware loop
        ctrl_immy = 8'd3;
        op(LDLP, 7'd0);
        check("ldlp_addr", 32'(u_address), 32'h201);
        check("ldlp_cnt", 32'(loop_count), 32'h3);
        for (int i = 0; i < 3; i++) begin
            op(LOOP, 7'd0);
            check($sformatf("loop%0d_addr", i), 32'(u_address), 32'h201);
            check($sformatf("loop%0d_cnt", i), 32'(loop_count), 32'(2 - i));
        end
        op(LOOP, 7'd0);
        check("loop_exit_addr", 32'(u_address), 32'h202);
        check("loop_exit_cnt", 32'(loop_count), 32'h0);

        // Trap dispatch, stall holding state and ignoring err_clr
        op(RET, 7'd0);
        check("unf_again", 32'(err_underflow), 32'h1);
        any_interruption = 1'b1;
        trap_u_address   = 14'h02AB;
        op(DISP, 7'd0);
        check("disp_trap", 32'(u_address), 32'h2AB);
        stall   = 1'b1;
        err_clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            op(CALL, 7'd4);
            check_al($sformatf("stall%0d", i), 32'h2AB, 0);
            check($sformatf("stall%0d_unf", i), 32'(err_underflow), 32'h1);
        end
        stall   = 1'b0;
        err_clr = 1'b0;
        op(CALL, 7'd4);
        check_al("unstall_call", 32'h2AF, 1);

        // Asynchronous reset mid-operation
        #3;
        arst_n = 1'b0;
        #1;
        check_al("async_rst", 32'h0, 0);
        check("async_rst_unf", 32'(err_underflow), 32'h0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
